serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial subtractor computing `d = a - b - bin` over `WIDTH` cycles, one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse counterpart of the team's ripple-carry adder chain. It trades area for latency and is used in datapaths where a full-width borrow chain is not justified. A start/busy/done handshake frames each operation.

## Interface
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when idle.
- `a`  in  WIDTH  minuend; latched on accepted start.
- `b`  in  WIDTH  subtrahend; latched on accepted start.
- `bin`  in  1  borrow-in; latched on accepted start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `d`  out  WIDTH  difference; held until the next completion.
- `bout`  out  1  borrow-out (unsigned a < b + bin); held with `d`.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN. A bit counter of `$clog2(WIDTH+1)` bits sits beside the FSM.
- IDLE, `start`=1 at an edge:
  - latch `a`, `b` into shift registers;
  - load the borrow register with `bin`;
  - clear the counter;
  - go to RUN.
- RUN, each edge processes bit i = counter value:
  - diff bit = a_i ^ b_i ^ br;
  - next br = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  - the diff bit shifts in at the MSB of the result shift register;
  - operand registers shift right.
- Edge processing bit WIDTH-1:
  - `d` ← completed result register;
  - `bout` ← final borrow;
  - `done` ← 1;
  - FSM → IDLE.
- `start` while in RUN is ignored. Operands may change freely after acceptance.
- `start` in the cycle where `done`=1 is accepted, because the FSM is already IDLE, giving back-to-back operation.
- All arithmetic is modulo 2^WIDTH. `bout` is the unsigned borrow out of the MSB.

## Timing
- Reset value of every output is 0: `busy`, `done`, `d`, `bout`, `ovf`. FSM resets to IDLE and the counter to 0.
- Start accepted at edge E0:
  - `busy`=1 from E0 through E(WIDTH);
  - `busy`=0 after E(WIDTH);
  - `done`=1 for exactly the cycle following E(WIDTH).
- Latency is WIDTH cycles from accepted start to visible `done`. Throughput is one operation per WIDTH cycles.
- `d`/`bout`/`ovf` change only at the completion edge (or reset) and are stable otherwise.
- `rst` mid-RUN:
  - operation aborts and no `done` is issued;
  - outputs return to 0;
  - the next `start` is accepted on the first edge after `rst` deasserts.
- `rst` and `start` high at the same edge: reset wins.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists;
  - at completion `ovf` ← (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the latched MSBs;
  - held like `d`; reset to 0.
- Not defined: no `ovf` port and no MSB capture logic. All other behaviour is identical.

## Test plan
- WIDTH=4, a=9, b=3, bin=0, start pulse → `busy` for 4 cycles, then `done` pulse with d=6, bout=0.
- a=3, b=9, bin=0 → d=0xA, bout=1. With the macro on, a=7, b=8 → d=0xF, bout=1, ovf=1.
- a=0, b=0, bin=1 → d=0xF, bout=1. a=5, b=5, bin=0 → d=0, bout=0.
- `start` re-asserted with different operands during RUN → ignored; the first result is unchanged. `start` during the `done` cycle → second result after exactly 4 more cycles.
- `rst` asserted at the 2nd RUN cycle → no `done`; all outputs 0. A fresh start of 12-4 then yields d=8.
- Randomized sweep, WIDTH=8, 1000 operations → d/bout match (a-b-bin) mod 256 and borrow. `d` is stable between `done` pulses.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock with a single borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic             diff;
    logic             br_nxt;
    logic             last;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    assign diff    = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // Result fills from the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign res_nxt = {diff, res_sh};
    assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (start) begin
                state_nxt = RUN;
            end
        end else if (last) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh <= a;
                    b_sh <= b;
                    br   <= bin;
                    cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
`endif
                end
            end else begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_nxt[WIDTH-1:1];
                br     <= br_nxt;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    d    <= res_nxt;
                    bout <= br_nxt;
                    done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= (a_msb != b_msb) && (diff != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: directed cases at WIDTH=4, randomized sweep at WIDTH=8.
module tb_serial_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    logic       rst4 = 1'b1, start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] d4;
    logic       rst8 = 1'b1, start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf4, ovf8;
`endif

    serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, borrow = negative result.
    function automatic exp_t model(input int w, input int a, input int b, input int bin, input int due);
        exp_t e;
        int   r;
        int   am, bm, dm;
        r     = a - b - bin;
        e.bo  = (r < 0);
        e.d   = 8'((r + 512) % (1 << w));
        am    = (a >> (w - 1)) & 1;
        bm    = (b >> (w - 1)) & 1;
        dm    = (int'(e.d) >> (w - 1)) & 1;
        e.ov  = (am != bm) && (dm != am);
        e.cyc = due;
        return e;
    endfunction

    // ---------------- monitors ----------------
    logic       rst4_seen = 1'b0, rst8_seen = 1'b0;
    logic [3:0] held4_d = '0;
    logic [7:0] held8_d = '0;
    logic       held4_b = 1'b0, held8_b = 1'b0, held4_o = 1'b0, held8_o = 1'b0;
    exp_t       m4, m8;

    always @(posedge clk) begin
        rst4_seen <= rst4;
        rst8_seen <= rst8;
    end

    always @(negedge clk) begin
        if (rst4_seen) begin
            held4_d = '0; held4_b = 1'b0; held4_o = 1'b0;
        end
        if (done4) begin
            if (q4.size() == 0) begin
                check("u4 unexpected done", 1, 0);
            end else begin
                m4 = q4.pop_front();
                check("u4 d", int'(d4), int'(m4.d[3:0]));
                check("u4 bout", int'(bout4), int'(m4.bo));
                check("u4 latency", cyc, m4.cyc);
                check("u4 busy at done", int'(busy4), 0);
`ifdef SERIAL_SUB_OVF_EN
                check("u4 ovf", int'(ovf4), int'(m4.ov));
                held4_o = m4.ov;
`endif
                held4_d = m4.d[3:0];
                held4_b = m4.bo;
            end
        end else begin
            check("u4 d held", int'(d4), int'(held4_d));
            check("u4 bout held", int'(bout4), int'(held4_b));
`ifdef SERIAL_SUB_OVF_EN
            check("u4 ovf held", int'(ovf4), int'(held4_o));
`endif
        end
    end

    always @(negedge clk) begin
        if (rst8_seen) begin
            held8_d = '0; held8_b = 1'b0; held8_o = 1'b0;
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("u8 unexpected done", 1, 0);
            end else begin
                m8 = q8.pop_front();
                check("u8 d", int'(d8), int'(m8.d));
                check("u8 bout", int'(bout8), int'(m8.bo));
                check("u8 latency", cyc, m8.cyc);
                check("u8 busy at done", int'(busy8), 0);
`ifdef SERIAL_SUB_OVF_EN
                check("u8 ovf", int'(ovf8), int'(m8.ov));
                held8_o = m8.ov;
`endif
                held8_d = m8.d;
                held8_b = m8.bo;
            end
        end else begin
            check("u8 d held", int'(d8), int'(held8_d));
            check("u8 bout held", int'(bout8), int'(held8_b));
`ifdef SERIAL_SUB_OVF_EN
            check("u8 ovf held", int'(ovf8), int'(held8_o));
`endif
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue4(input int a, input int b, input int bin);
        start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin);
        q4.push_back(model(4, a, b, bin, cyc + 1 + 4));
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        check("u4 busy after accept", int'(busy4), 1);
    endtask

    task automatic wait4();
        int n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done4) check("u4 done timeout", 0, 1);
    endtask

    task automatic issue8(input int a, input int b, input int bin);
        start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin);
        q8.push_back(model(8, a, b, bin, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic wait8();
        int n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) check("u8 done timeout", 0, 1);
    endtask

    // ---------------- sequences ----------------
    int ta[5] = '{9, 3, 7, 0, 5};
    int tb[5] = '{3, 9, 8, 0, 5};
    int tc[5] = '{0, 0, 0, 1, 0};

    initial begin
        fork
            begin
                repeat (3) @(negedge clk);
                check("u4 reset busy", int'(busy4), 0);
                check("u4 reset done", int'(done4), 0);
                check("u4 reset d", int'(d4), 0);
                check("u4 reset bout", int'(bout4), 0);
                rst4 = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    issue4(ta[i], tb[i], tc[i]);
                    wait4();
                end
                // start during RUN must be ignored
                @(negedge clk);
                issue4(9, 3, 0);
                start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
                @(negedge clk);
                start4 = 1'b0;
                wait4();
                // back-to-back: start in the done cycle
                @(negedge clk);
                issue4(2, 1, 0);
                wait4();
                issue4(12, 5, 0);
                wait4();
                // reset in the 2nd RUN cycle aborts
                @(negedge clk);
                issue4(9, 3, 0);
                rst4 = 1'b1;
                @(negedge clk);
                rst4 = 1'b0;
                q4.delete();
                check("u4 abort busy", int'(busy4), 0);
                check("u4 abort done", int'(done4), 0);
                check("u4 abort d", int'(d4), 0);
                check("u4 abort bout", int'(bout4), 0);
                repeat (8) @(negedge clk);
                issue4(12, 4, 0);
                wait4();
                // reset and start at the same edge: reset wins
                @(negedge clk);
                rst4 = 1'b1; start4 = 1'b1; a4 = 4'd5; b4 = 4'd1;
                @(negedge clk);
                rst4 = 1'b0; start4 = 1'b0;
                check("u4 rst beats start", int'(busy4), 0);
                issue4(6, 2, 0);
                wait4();
                repeat (6) @(negedge clk);
            end
            begin
                repeat (2) @(negedge clk);
                check("u8 reset busy", int'(busy8), 0);
                check("u8 reset d", int'(d8), 0);
                rst8 = 1'b0;
                @(negedge clk);
                for (int i = 0; i < 1000; i++) begin
                    issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 1)));
                    if ($urandom_range(0, 1) == 1) begin
                        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
                        @(negedge clk);
                        start8 = 1'b0;
                    end
                    wait8();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                repeat (12) @(negedge clk);
            end
        join
        check("u4 queue drained", q4.size(), 0);
        check("u8 queue drained", q8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
